// File: rtl/ox_pattern_classifier.sv
// Classifies a 3x3 VAE reconstruction as circle (MARU), cross (BATU) or reject.
// Snapshot, serial binarisation, then Hamming compare against both templates.
module ox_pattern_classifier #(
  parameter logic [15:0] THRESH   = 16'h8000,
  parameter int unsigned MAX_DIST = 2,
  parameter int unsigned COUNT_W  = 8,
  parameter logic [8:0]  MARU_T   = 9'b111101111,
  parameter logic [8:0]  BATU_T   = 9'b101010101
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               train_done,
  input  logic               start,
  input  logic [15:0]        Out1,
  input  logic [15:0]        Out2,
  input  logic [15:0]        Out3,
  input  logic [15:0]        Out4,
  input  logic [15:0]        Out5,
  input  logic [15:0]        Out6,
  input  logic [15:0]        Out7,
  input  logic [15:0]        Out8,
  input  logic [15:0]        Out9,
  output logic               busy,
  output logic               done,
  output logic [8:0]         bits,
  output logic [3:0]         dist_maru,
  output logic [3:0]         dist_batu,
  output logic               is_maru,
  output logic               is_batu,
  output logic               reject,
  output logic [COUNT_W-1:0] maru_count,
  output logic [COUNT_W-1:0] batu_count
);

  localparam int unsigned NPIX   = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DIST_W = 4;
  localparam logic [DIST_W-1:0]  MAX_D     = DIST_W'(MAX_DIST);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NPIX - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        hold_q [NPIX];
  logic [15:0]        hold_d [NPIX];
  logic [8:0]         shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [8:0]         bits_q, bits_d;
  logic [DIST_W-1:0]  dist_maru_q, dist_maru_d;
  logic [DIST_W-1:0]  dist_batu_q, dist_batu_d;
  logic               is_maru_q, is_maru_d;
  logic               is_batu_q, is_batu_d;
  logic               reject_q, reject_d;
  logic [COUNT_W-1:0] maru_count_q, maru_count_d;
  logic [COUNT_W-1:0] batu_count_q, batu_count_d;

  logic               pix_c;
  logic [DIST_W-1:0]  dm_c, db_c;
  logic               maru_hit_c, batu_hit_c;

  function automatic logic [DIST_W-1:0] popcnt9(input logic [8:0] v);
    logic [DIST_W-1:0] s;
    s = '0;
    for (int i = 0; i < 9; i++) s = s + DIST_W'(v[i]);
    return s;
  endfunction

  // Current pixel and template distances, consumed by SCAN and COMPARE respectively
  always_comb begin
    pix_c      = (hold_q[idx_q] >= THRESH);
    dm_c       = popcnt9(shift_q ^ MARU_T);
    db_c       = popcnt9(shift_q ^ BATU_T);
    maru_hit_c = (dm_c < db_c) && (dm_c <= MAX_D);
    batu_hit_c = (db_c < dm_c) && (db_c <= MAX_D);
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    bits_d       = bits_q;
    dist_maru_d  = dist_maru_q;
    dist_batu_d  = dist_batu_q;
    is_maru_d    = is_maru_q;
    is_batu_d    = is_batu_q;
    reject_d     = reject_q;
    maru_count_d = maru_count_q;
    batu_count_d = batu_count_q;
    case (state_q)
      IDLE: begin
        if (start && train_done) begin
          hold_d  = '{Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8, Out9};
          shift_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // MSB first: Out1 ends up in bit 8 after nine shifts
        shift_d = {shift_q[7:0], pix_c};
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = COMPARE;
      end
      COMPARE: begin
        bits_d      = shift_q;
        dist_maru_d = dm_c;
        dist_batu_d = db_c;
        is_maru_d   = maru_hit_c;
        is_batu_d   = batu_hit_c;
        reject_d    = !(maru_hit_c || batu_hit_c);
        if (maru_hit_c && (maru_count_q != COUNT_MAX))
          maru_count_d = maru_count_q + COUNT_W'(1);
        if (batu_hit_c && (batu_count_q != COUNT_MAX))
          batu_count_d = batu_count_q + COUNT_W'(1);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      for (int i = 0; i < NPIX; i++) hold_q[i] <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bits_q       <= '0;
      dist_maru_q  <= '0;
      dist_batu_q  <= '0;
      is_maru_q    <= 1'b0;
      is_batu_q    <= 1'b0;
      reject_q     <= 1'b0;
      maru_count_q <= '0;
      batu_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      bits_q       <= bits_d;
      dist_maru_q  <= dist_maru_d;
      dist_batu_q  <= dist_batu_d;
      is_maru_q    <= is_maru_d;
      is_batu_q    <= is_batu_d;
      reject_q     <= reject_d;
      maru_count_q <= maru_count_d;
      batu_count_q <= batu_count_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bits       = bits_q;
  assign dist_maru  = dist_maru_q;
  assign dist_batu  = dist_batu_q;
  assign is_maru    = is_maru_q;
  assign is_batu    = is_batu_q;
  assign reject     = reject_q;
  assign maru_count = maru_count_q;
  assign batu_count = batu_count_q;

endmodule

// File: tb/tb_ox_pattern_classifier.sv
// Directed self-checking bench for ox_pattern_classifier (default and COUNT_W=2 instances).
module tb_ox_pattern_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        train_done;
  logic        start;
  logic        start2;
  logic [15:0] Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8, Out9;

  logic        busy, done, is_maru, is_batu, reject;
  logic [8:0]  bits;
  logic [3:0]  dist_maru, dist_batu;
  logic [7:0]  maru_count, batu_count;

  logic        busy2, done2, is_maru2, is_batu2, reject2;
  logic [8:0]  bits2;
  logic [3:0]  dist_maru2, dist_batu2;
  logic [1:0]  maru_count2, batu_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ox_pattern_classifier dut (
    .clk(clk), .rst(rst), .train_done(train_done), .start(start),
    .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4), .Out5(Out5),
    .Out6(Out6), .Out7(Out7), .Out8(Out8), .Out9(Out9),
    .busy(busy), .done(done), .bits(bits),
    .dist_maru(dist_maru), .dist_batu(dist_batu),
    .is_maru(is_maru), .is_batu(is_batu), .reject(reject),
    .maru_count(maru_count), .batu_count(batu_count)
  );

  ox_pattern_classifier #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .train_done(train_done), .start(start2),
    .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4), .Out5(Out5),
    .Out6(Out6), .Out7(Out7), .Out8(Out8), .Out9(Out9),
    .busy(busy2), .done(done2), .bits(bits2),
    .dist_maru(dist_maru2), .dist_batu(dist_batu2),
    .is_maru(is_maru2), .is_batu(is_batu2), .reject(reject2),
    .maru_count(maru_count2), .batu_count(batu_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pat(input logic [8:0] p);
    Out1 = p[8] ? 16'hFFFF : 16'h0000;
    Out2 = p[7] ? 16'hFFFF : 16'h0000;
    Out3 = p[6] ? 16'hFFFF : 16'h0000;
    Out4 = p[5] ? 16'hFFFF : 16'h0000;
    Out5 = p[4] ? 16'hFFFF : 16'h0000;
    Out6 = p[3] ? 16'hFFFF : 16'h0000;
    Out7 = p[2] ? 16'hFFFF : 16'h0000;
    Out8 = p[1] ? 16'hFFFF : 16'h0000;
    Out9 = p[0] ? 16'hFFFF : 16'h0000;
  endtask

  task automatic chk_results(input string tag, input logic [8:0] eb, input logic [3:0] edm,
                             input logic [3:0] edb, input logic em, input logic ebt,
                             input logic er, input logic [7:0] emc, input logic [7:0] ebc);
    chk({tag, ".bits"},   32'(bits), 32'(eb));
    chk({tag, ".dmaru"},  32'(dist_maru), 32'(edm));
    chk({tag, ".dbatu"},  32'(dist_batu), 32'(edb));
    chk({tag, ".class"},  32'({is_maru, is_batu, reject}), 32'({em, ebt, er}));
    chk({tag, ".counts"}, 32'({maru_count, batu_count}), 32'({emc, ebc}));
  endtask

  // Start at E0, expect done exactly at E0+10 and the given results
  task automatic run(input string tag, input logic [8:0] eb, input logic [3:0] edm,
                     input logic [3:0] edb, input logic em, input logic ebt,
                     input logic er, input logic [7:0] emc, input logic [7:0] ebc);
    int early;
    early = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (done) early++;
    end
    chk({tag, ".early_done"}, 32'(early), 32'd0);
    step();
    chk({tag, ".done"}, 32'({done, busy}), 32'b10);
    chk_results(tag, eb, edm, edb, em, ebt, er, emc, ebc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; train_done = 1'b1; start = 1'b0; start2 = 1'b0;
    set_pat(9'b0);
    step(); step();
    chk("reset.busy_done", 32'({busy, done, busy2, done2}), 32'd0);
    chk_results("reset", 9'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    rst = 1'b0;
    step();

    set_pat(9'b111101111);
    run("maru", 9'b111101111, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    step();
    chk("maru.done_pulse", 32'(done), 32'd0);

    set_pat(9'b001010101);
    run("batu", 9'b001010101, 4'd6, 4'd1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1);

    set_pat(9'b000000000);
    run("zero", 9'b000000000, 4'd8, 4'd5, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);

    set_pat(9'b0); Out1 = 16'h8000;
    run("thr8000", 9'b100000000, 4'd7, 4'd4, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);

    set_pat(9'b0); Out1 = 16'h7FFF;
    run("thr7fff", 9'b000000000, 4'd8, 4'd5, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);

    set_pat(9'b111101100);
    run("dist2", 9'b111101100, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1);

    set_pat(9'b111100100);
    run("dist3", 9'b111100100, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1);

    // Start without train_done is dropped
    train_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy || done) seen++;
      step();
    end
    chk("notrain.idle", 32'(seen), 32'd0);
    chk_results("notrain", 9'b111100100, 4'd3, 4'd4, 1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
    train_done = 1'b1;

    // Snapshot held, input changes ignored, mid-scan start ignored, old results held
    set_pat(9'b101010101);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("snap.bits_held", 32'(bits), 32'(9'b111100100));
    step();
    set_pat(9'b111111111);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 4; i <= 9; i++) begin
      step();
      if (done) seen++;
    end
    step();
    chk("snap.done", 32'({seen[3:0], done}), 32'b00001);
    chk_results("snap", 9'b101010101, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done || busy) seen++;
    end
    chk("snap.no_requeue", 32'(seen), 32'd0);

    // Reset mid-scan aborts
    set_pat(9'b001010101);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.busy_done", 32'({busy, done}), 32'd0);
    chk_results("midrst", 9'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) seen++;
    end
    chk("midrst.no_done", 32'(seen), 32'd0);
    set_pat(9'b111101111);
    run("fresh", 9'b111101111, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    step(); step();

    // COUNT_W=2 saturation, restarting on each done cycle
    for (int r = 0; r < 5; r++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (r < 3) ? 2'(r + 1) : 2'd3;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      seen = 0;
      for (int i = 1; i <= 9; i++) begin
        step();
        if (done2) seen++;
      end
      step();
      chk($sformatf("sat%0d.done", r), 32'({seen[3:0], done2, is_maru2}), 32'b000011);
      chk($sformatf("sat%0d.count", r), 32'({maru_count2, batu_count2}), 32'({exp_cnt, 2'd0}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
